// File: rtl/pipe_dmem_responder.sv
// Multi-cycle data-memory responder for the MEM-stage load/store port.
// Accepts one word access, inserts LATENCY wait states, performs the access
// on an internal word array, then pulses rsp_valid for one cycle.
module pipe_dmem_responder #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [15:0]       stall_count
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state, state_nxt;
  logic [3:0]          wait_cnt;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                accept;
  logic                access;

  // Next-state and handshake decode; DONE ignores req_valid so the
  // still-held completed request is not taken a second time.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    access    = 1'b0;
    case (state)
      IDLE: begin
        stall = req_valid;
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (wait_cnt == 4'd0) begin
          access    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, wait counter and request-field latch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        wait_cnt  <= 4'(LATENCY - 1);
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end else if (state == BUSY && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  // Word array: cleared on reset, written on the access edge of a store.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (access && lat_we) begin
      mem[lat_addr] <= lat_wdata;
    end
  end

  // Read data register; only loads do update it, so it holds across writes.
  always_ff @(posedge clk) begin
    if (!reset)                  rsp_rdata <= '0;
    else if (access && !lat_we)  rsp_rdata <= mem[lat_addr];
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (!reset)                          stall_count <= 16'd0;
    else if (stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
  end

endmodule

// File: tb/tb_pipe_dmem_responder.sv
// Directed bench for pipe_dmem_responder with a response scoreboard.
module tb_pipe_dmem_responder;

  localparam int LAT = 2;

  typedef struct {
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic        stall, rsp_valid;
  logic [31:0] rsp_rdata;
  logic [15:0] stall_count;

  logic        reset_s, req_valid_s;
  logic        stall_s, rsp_valid_s;
  logic [31:0] rsp_rdata_s;
  logic [15:0] stall_count_s;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipe_dmem_responder #(.ADDR_W(5), .DATA_W(32), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .stall_count(stall_count)
  );

  // Long-latency instance kept permanently busy to reach counter saturation.
  pipe_dmem_responder #(.ADDR_W(5), .DATA_W(32), .LATENCY(15)) u_sat (
    .clk(clk), .reset(reset_s), .req_valid(req_valid_s), .req_we(1'b0),
    .req_addr(5'd0), .req_wdata(32'd0), .stall(stall_s),
    .rsp_valid(rsp_valid_s), .rsp_rdata(rsp_rdata_s), .stall_count(stall_count_s)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every response must match the oldest expectation.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  // Issue one access starting this cycle and hold it until the DONE cycle.
  task automatic access(input logic we, input logic [4:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input bit chg);
    int  n0;
    bit  got;
    n0 = cyc;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    sb.push_back('{exp_rd, n0 + LAT + 1});
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      chk("stall", {31'd0, stall}, {31'd0, (k <= LAT)});
      if (chg && k == 1) begin
        req_addr  = a + 5'd1;
        req_wdata = 32'h22;
      end
      if (rsp_valid) got = 1'b1;
    end
    if (!got) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    reset_s = 1'b0; req_valid_s = 1'b1;

    // Reset held two edges with a request pending.
    next_cycle();
    reset_s = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("rst_stall_follows_req", {31'd0, stall}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_stall_count", {16'd0, stall_count}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    req_valid = 1'b0;
    #1;
    chk("rst_stall_idle", {31'd0, stall}, 32'd0);
    next_cycle();
    reset = 1'b1;

    // Write then back-to-back read.
    access(1'b1, 5'd5, 32'hDEADBEEF, 32'd0, 1'b0);
    next_cycle();
    access(1'b0, 5'd5, 32'd0, 32'hDEADBEEF, 1'b0);
    chk("stall_count_6", {16'd0, stall_count}, 32'd6);

    // Request held through DONE must not be re-accepted.
    next_cycle();
    access(1'b1, 5'd9, 32'h1234, 32'hDEADBEEF, 1'b0);
    next_cycle();
    req_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("no_reaccept_stall", {31'd0, stall}, 32'd0);
    end
    next_cycle();
    access(1'b0, 5'd9, 32'd0, 32'h1234, 1'b0);

    // Request fields changing while busy are ignored.
    next_cycle();
    access(1'b1, 5'd3, 32'h11, 32'h1234, 1'b1);
    next_cycle();
    access(1'b0, 5'd3, 32'd0, 32'h11, 1'b0);
    next_cycle();
    access(1'b0, 5'd4, 32'd0, 32'd0, 1'b0);

    // Reset during the final wait cycle of a write abandons it.
    next_cycle();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd7; req_wdata = 32'hAA;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    req_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    chk("midrst_stall_count", {16'd0, stall_count}, 32'd0);
    chk("midrst_rsp_rdata", rsp_rdata, 32'd0);
    next_cycle();
    reset = 1'b1;
    access(1'b0, 5'd5, 32'd0, 32'd0, 1'b0);
    next_cycle();
    access(1'b0, 5'd7, 32'd0, 32'd0, 1'b0);
    next_cycle();
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);

    // Saturation on the LATENCY=15 instance.
    while (cyc < 71000) @(posedge clk);
    @(negedge clk);
    chk("sat_stall_count", {16'd0, stall_count_s}, 32'h0000FFFF);
    repeat (500) @(negedge clk);
    chk("sat_hold", {16'd0, stall_count_s}, 32'h0000FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
